// File: rtl/fixed_accumulator.sv
// Two-stage signed fixed-point accumulator: sums one vector of terms onto a bias and strobes the result.
// Optional build macro FIXED_ACC_SATURATE_EN clamps on overflow instead of wrapping.
module fixed_accumulator #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 43,
  parameter int unsigned MAX_TERMS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  input  logic [ACC_WIDTH-1:0] bias_in,
  output logic [ACC_WIDTH-1:0] fixed_out,
  output logic                 out_valid,
  output logic                 ovf_out,
  output logic                 len_err,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(MAX_TERMS);

`ifdef FIXED_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                       r_state, w_state_next;
  logic [CntW-1:0]              r_term_cnt, w_term_cnt_next;
  logic                         w_first, w_force, w_eff_last;

  logic                         r_s0_valid, r_s0_first, r_s0_last, r_s0_len;
  logic signed [ACC_WIDTH-1:0]  r_s0_term, r_s0_bias;
  logic signed [ACC_WIDTH-1:0]  w_term_ext;

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_ovf;
  logic                         r_s1_open;
  logic signed [ACC_WIDTH-1:0]  w_base;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic signed [ACC_WIDTH-1:0]  w_res;
  logic                         w_ovf, w_ovf_vec;

  logic [ACC_WIDTH-1:0]         r_fixed;
  logic                         r_out_valid, r_ovf_out, r_len_err;

  assign w_term_ext = ACC_WIDTH'($signed(in_data));

  // Vector framing: a beat at the last allowed index is forced closed.
  always_comb begin
    w_first         = (r_state == StIdle);
    w_force         = (r_term_cnt == CntW'(MAX_TERMS - 1)) && !in_last;
    w_eff_last      = in_last || w_force;
    w_state_next    = r_state;
    w_term_cnt_next = r_term_cnt;
    if (in_valid) begin
      if (w_eff_last) begin
        w_state_next    = StIdle;
        w_term_cnt_next = '0;
      end else begin
        w_state_next    = StAccum;
        w_term_cnt_next = r_term_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_term_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_term_cnt <= w_term_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s0_valid <= 1'b0;
      r_s0_first <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_len   <= 1'b0;
      r_s0_term  <= '0;
      r_s0_bias  <= '0;
    end else begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_first <= w_first;
        r_s0_last  <= w_eff_last;
        r_s0_len   <= w_force;
        r_s0_term  <= w_term_ext;
        if (w_first) begin
          r_s0_bias <= bias_in;
        end
      end
    end
  end

  // One extra bit of sum exposes signed overflow as a mismatch of the top two bits.
  always_comb begin
    w_base = r_s0_first ? r_s0_bias : r_acc;
    w_sum  = (ACC_WIDTH+1)'(w_base) + (ACC_WIDTH+1)'(r_s0_term);
    w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
`ifdef FIXED_ACC_SATURATE_EN
    if (w_ovf) begin
      w_res = w_sum[ACC_WIDTH] ? AccMin : AccMax;
    end else begin
      w_res = w_sum[ACC_WIDTH-1:0];
    end
`else
    w_res = w_sum[ACC_WIDTH-1:0];
`endif
    w_ovf_vec = (r_s0_first ? 1'b0 : r_ovf) | w_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_s1_open   <= 1'b0;
      r_fixed     <= '0;
      r_out_valid <= 1'b0;
      r_ovf_out   <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_s1_open   <= 1'b0;
      if (r_s0_valid) begin
        r_acc     <= w_res;
        r_ovf     <= w_ovf_vec;
        r_s1_open <= !r_s0_last;
        if (r_s0_last) begin
          r_fixed     <= w_res;
          r_out_valid <= 1'b1;
          r_ovf_out   <= w_ovf_vec;
          r_len_err   <= r_s0_len;
        end
      end
    end
  end

  assign fixed_out = r_fixed;
  assign out_valid = r_out_valid;
  assign ovf_out   = r_ovf_out;
  assign len_err   = r_len_err;
  assign busy      = (r_state == StAccum) || r_s0_valid || r_s1_open;

endmodule
